// File: rtl/nim_ts_pkg.sv
// Shared entry layout and constants for the NIM trigger timestamper.
package nim_ts_pkg;
    localparam int          TS_W_C  = 48;
    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    typedef struct packed {
        logic [7:0]  mask;
        logic [7:0]  seq;
        logic [47:0] ts;
    } ts_entry_t;
endpackage

// File: rtl/nim_trig_timestamper_if.sv
// Event readout stream: first-word-fall-through valid/ready towards the PS/AXI side.
interface nim_trig_timestamper_if;
    import nim_ts_pkg::*;

    ts_entry_t dout;
    logic      dout_valid;
    logic      dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/nim_ts_fifo_mem.sv
// Simple dual-port event store, one write and one registered read port.
module nim_ts_fifo_mem
    import nim_ts_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ts_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output ts_entry_t     rdata
);
    ts_entry_t mem [DEPTH];

    // Read-during-write on the same address returns the old word; the parent bypasses that case.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/nim_trig_timestamper.sv
// Rising-edge trigger timestamper: merges coincident edges into one 48-bit-stamped
// entry and buffers entries in a FWFT FIFO with drop counting.
module nim_trig_timestamper
    import nim_ts_pkg::*;
#(
    parameter int N_CH  = 6,
    parameter int TS_W  = 48,
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        trig_in,
    input  logic                   enable,
    input  logic [N_CH-1:0]        chan_mask,
    input  logic                   clear,
    input  logic                   ts_reset,
    nim_trig_timestamper_if.master rd,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [15:0]            overflow_cnt
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   LEVEL_MAX = (AW+1)'(DEPTH);

    logic [TS_W-1:0] ts_reg;
    logic [N_CH-1:0] trig_d_reg;
    logic [7:0]      seq_reg;
    ts_entry_t       ev_reg;
    logic            ev_valid_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     level_reg;
    logic [15:0]     ovf_reg;
    logic            byp_sel_reg;
    ts_entry_t       byp_reg;
    ts_entry_t       mem_rdata;

    logic [N_CH-1:0] edge_vec;
    logic            has_data;
    logic            is_full;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            byp_sel_next;
    logic [AW-1:0]   rd_ptr_next;
    logic [AW:0]     level_next;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_edge
            assign edge_vec[gi] = enable & chan_mask[gi] & trig_in[gi] & ~trig_d_reg[gi];
        end
    endgenerate

    // The RAM always reads the head the FIFO will have after this cycle, so a
    // pop is followed by the next entry on dout one cycle later.
    always_comb begin
        has_data     = (level_reg != '0);
        is_full      = (level_reg == LEVEL_MAX);
        pop          = has_data & rd.dout_ready;
        push_ok      = ev_valid_reg & (~is_full | pop);
        drop         = ev_valid_reg & is_full & ~pop;
        rd_ptr_next  = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        // Entry lands in the slot being read this edge: the RAM would return stale data.
        byp_sel_next = push_ok & ~clear & (wr_ptr_reg == rd_ptr_next);
        level_next   = level_reg;
        if (clear) begin
            level_next = '0;
        end else if (push_ok && !pop) begin
            level_next = level_reg + 1'b1;
        end else if (pop && !push_ok) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_reg       <= '0;
            trig_d_reg   <= '0;
            seq_reg      <= '0;
            ev_reg       <= '0;
            ev_valid_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            ovf_reg      <= '0;
            byp_sel_reg  <= 1'b0;
            byp_reg      <= '0;
        end else begin
            ts_reg      <= ts_reset ? '0 : ts_reg + 1'b1;
            trig_d_reg  <= trig_in;
            level_reg   <= level_next;
            byp_sel_reg <= byp_sel_next;
            if (byp_sel_next) begin
                byp_reg <= ev_reg;
            end
            if (clear) begin
                seq_reg      <= '0;
                ev_valid_reg <= 1'b0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                ovf_reg      <= '0;
            end else begin
                ev_valid_reg <= |edge_vec;
                if (|edge_vec) begin
                    ev_reg.mask <= 8'(edge_vec);
                    ev_reg.seq  <= seq_reg;
                    ev_reg.ts   <= TS_W_C'(ts_reg);
                    seq_reg     <= seq_reg + 1'b1;
                end
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                rd_ptr_reg <= rd_ptr_next;
                if (drop && ovf_reg != OVF_MAX) begin
                    ovf_reg <= ovf_reg + 1'b1;
                end
            end
        end
    end

    nim_ts_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push_ok & ~clear),
        .waddr (wr_ptr_reg),
        .wdata (ev_reg),
        .raddr (rd_ptr_next),
        .rdata (mem_rdata)
    );

    assign rd.dout       = has_data ? (byp_sel_reg ? byp_reg : mem_rdata) : '0;
    assign rd.dout_valid = has_data;
    assign level         = level_reg;
    assign full          = is_full;
    assign overflow_cnt  = ovf_reg;
endmodule

// File: tb/tb_nim_trig_timestamper.sv
// Scoreboard bench for nim_trig_timestamper: expected entries are queued as edges are driven.
module tb_nim_trig_timestamper;
    import nim_ts_pkg::*;

    localparam int N_CH  = 6;
    localparam int DEPTH = 512;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_CH-1:0]        trig_in = '0;
    logic                   enable = 1'b0;
    logic [N_CH-1:0]        chan_mask = '0;
    logic                   clear = 1'b0;
    logic                   ts_reset = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic [15:0]            overflow_cnt;

    int        checks = 0;
    int        failures = 0;
    int        exp_seq = 0;
    logic [47:0] m_ts;
    ts_entry_t sb_q [$];

    nim_trig_timestamper_if rd();

    nim_trig_timestamper #(.N_CH(N_CH), .TS_W(48), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trig_in      (trig_in),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .clear        (clear),
        .ts_reset     (ts_reset),
        .rd           (rd),
        .level        (level),
        .full         (full),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value the counter holds during the current cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      m_ts <= 48'd0;
        else if (ts_reset) m_ts <= 48'd0;
        else               m_ts <= m_ts + 48'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // One-cycle rise on the given channels; queues the expected entry when it should be stored.
    task automatic fire(input logic [N_CH-1:0] bits, input bit store);
        ts_entry_t e;
        e.mask = 8'(bits);
        e.seq  = 8'(exp_seq);
        e.ts   = m_ts;
        trig_in = bits;
        if (store) sb_q.push_back(e);
        exp_seq++;
        @(negedge clk);
        trig_in = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        chan_mask = '1;
        rd.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (rd.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd.dout_valid); end
        checks++; if (rd.dout !== 64'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", rd.dout); end
        checks++; if (overflow_cnt !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL release_level got=%0d exp=0", level); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        ts_entry_t exp;
        int n = 0;
        rd.dout_ready = 1'b1;
        while (m_ts != 48'd100 && n < 200) begin @(negedge clk); n++; end
        checks++; if (m_ts != 48'd100) begin failures++; $display("FAIL single_wait_ts got=%0d exp=100", m_ts); end
        exp.mask = 8'h01; exp.seq = 8'(exp_seq); exp.ts = 48'd100;
        sb_q.push_back(exp);
        exp_seq++;
        trig_in = 6'b000001;
        @(negedge clk);
        trig_in = '0;
        checks++; if (rd.dout_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n1 got=%b exp=0", rd.dout_valid); end
        @(negedge clk);
        checks++; if (rd.dout_valid !== 1'b1) begin failures++; $display("FAIL single_valid_n2 got=%b exp=1", rd.dout_valid); end
        exp = sb_q.pop_front();
        checks++; if (rd.dout !== exp) begin failures++; $display("FAIL single_entry got=%h exp=%h", rd.dout, exp); end
        @(negedge clk);
        checks++; if (rd.dout_valid !== 1'b0 || level !== '0) begin
            failures++; $display("FAIL single_after_pop valid=%b level=%0d exp valid=0 level=0", rd.dout_valid, level);
        end
        $display("test_single done");
    endtask

    task automatic test_coincident();
        ts_entry_t exp;
        int seen = 0;
        exp.mask = 8'h24; exp.seq = 8'(exp_seq); exp.ts = m_ts;
        sb_q.push_back(exp);
        exp_seq++;
        trig_in = 6'b100100;
        for (int c = 0; c < 70; c++) begin
            if (c == 52) enable = 1'b0;
            if (c == 54) trig_in = 6'b110100;
            if (c == 58) enable = 1'b1;
            if (c == 66) trig_in = '0;
            if (rd.dout_valid) begin
                seen++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++; $display("FAIL coincident_extra got=%h exp=none", rd.dout);
                end else begin
                    exp = sb_q.pop_front();
                    if (rd.dout !== exp) begin failures++; $display("FAIL coincident_entry got=%h exp=%h", rd.dout, exp); end
                end
            end
            @(negedge clk);
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL coincident_count got=%0d exp=1", seen); end
        $display("test_coincident done");
    endtask

    task automatic test_overflow();
        ts_entry_t exp;
        int n = 0;
        clear = 1'b1;
        rd.dout_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        exp_seq = 0;
        for (int i = 0; i < 520; i++) fire(6'(1 << (i % N_CH)), i < DEPTH);
        checks++; if (level !== 10'd512) begin failures++; $display("FAIL ovf_level got=%0d exp=512", level); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
        checks++; if (overflow_cnt !== 16'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", overflow_cnt); end
        rd.dout_ready = 1'b1;
        while (sb_q.size() != 0 && n < 700) begin
            if (rd.dout_valid) begin
                exp = sb_q.pop_front();
                checks++;
                if (rd.dout !== exp) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", rd.dout, exp); end
            end
            @(negedge clk);
            n++;
        end
        checks++; if (sb_q.size() != 0 || n != 512) begin
            failures++; $display("FAIL ovf_back_to_back cycles=%0d left=%0d exp cycles=512 left=0", n, sb_q.size());
        end
        checks++; if (level !== '0) begin failures++; $display("FAIL ovf_drained_level got=%0d exp=0", level); end
        fire(6'b000001, 1'b1);
        checks++; if (rd.dout_valid !== 1'b1 || rd.dout.seq !== 8'd8) begin
            failures++; $display("FAIL ovf_next_seq valid=%b seq=%0d exp valid=1 seq=8", rd.dout_valid, rd.dout.seq);
        end
        exp = sb_q.pop_front();
        checks++; if (rd.dout !== exp) begin failures++; $display("FAIL ovf_next_entry got=%h exp=%h", rd.dout, exp); end
        @(negedge clk);
        $display("test_overflow done");
    endtask

    task automatic test_full_push_pop();
        ts_entry_t exp;
        int n = 0;
        rd.dout_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) fire(6'(1 << ((i + 3) % N_CH)), 1'b1);
        checks++; if (full !== 1'b1 || level !== 10'd512) begin
            failures++; $display("FAIL fpp_prefill full=%b level=%0d exp full=1 level=512", full, level);
        end
        exp.mask = 8'h10; exp.seq = 8'(exp_seq); exp.ts = m_ts;
        sb_q.push_back(exp);
        exp_seq++;
        trig_in = 6'b010000;
        @(negedge clk);
        trig_in = '0;
        rd.dout_ready = 1'b1;
        exp = sb_q.pop_front();
        checks++; if (rd.dout !== exp) begin failures++; $display("FAIL fpp_pop_entry got=%h exp=%h", rd.dout, exp); end
        @(negedge clk);
        rd.dout_ready = 1'b0;
        checks++; if (level !== 10'd512 || full !== 1'b1) begin
            failures++; $display("FAIL fpp_level level=%0d full=%b exp level=512 full=1", level, full);
        end
        checks++; if (overflow_cnt !== 16'd8) begin failures++; $display("FAIL fpp_ovf got=%0d exp=8", overflow_cnt); end
        rd.dout_ready = 1'b1;
        while (sb_q.size() != 0 && n < 700) begin
            if (rd.dout_valid) begin
                exp = sb_q.pop_front();
                checks++;
                if (rd.dout !== exp) begin failures++; $display("FAIL fpp_drain got=%h exp=%h", rd.dout, exp); end
            end
            @(negedge clk);
            n++;
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL fpp_drain_timeout left=%0d exp=0", sb_q.size()); end
        $display("test_full_push_pop done");
    endtask

    task automatic test_ts_reset();
        ts_entry_t exp;
        int n = 0;
        rd.dout_ready = 1'b0;
        ts_reset = 1'b1;
        @(negedge clk);
        ts_reset = 1'b0;
        while (m_ts != 48'd1000 && n < 1100) begin @(negedge clk); n++; end
        checks++; if (m_ts != 48'd1000) begin failures++; $display("FAIL tsr_wait got=%0d exp=1000", m_ts); end
        exp.mask = 8'h02; exp.seq = 8'(exp_seq); exp.ts = 48'd1000;
        sb_q.push_back(exp);
        exp_seq++;
        ts_reset = 1'b1;
        trig_in = 6'b000010;
        @(negedge clk);
        ts_reset = 1'b0;
        trig_in = '0;
        repeat (9) @(negedge clk);
        exp.mask = 8'h02; exp.seq = 8'(exp_seq); exp.ts = 48'd9;
        sb_q.push_back(exp);
        exp_seq++;
        trig_in = 6'b000010;
        @(negedge clk);
        trig_in = '0;
        rd.dout_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            if (rd.dout_valid) begin
                exp = sb_q.pop_front();
                checks++;
                if (rd.dout !== exp) begin failures++; $display("FAIL tsr_entry got=%h exp=%h", rd.dout, exp); end
            end
            @(negedge clk);
            n++;
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL tsr_timeout left=%0d exp=0", sb_q.size()); end
        $display("test_ts_reset done");
    endtask

    task automatic test_clear();
        ts_entry_t exp;
        int n = 0;
        rd.dout_ready = 1'b0;
        for (int i = 0; i < 30; i++) fire(6'(1 << (i % N_CH)), 1'b1);
        checks++; if (level !== 10'd30) begin failures++; $display("FAIL clr_prefill got=%0d exp=30", level); end
        clear = 1'b1;
        trig_in = 6'b001000;
        rd.dout_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        trig_in = '0;
        rd.dout_ready = 1'b0;
        sb_q.delete();
        exp_seq = 0;
        checks++; if (level !== '0) begin failures++; $display("FAIL clr_level got=%0d exp=0", level); end
        checks++; if (rd.dout_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", rd.dout_valid); end
        checks++; if (overflow_cnt !== 16'd0) begin failures++; $display("FAIL clr_ovf got=%0d exp=0", overflow_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL clr_no_entry got=%0d exp=0", level); end
        rd.dout_ready = 1'b1;
        fire(6'b000001, 1'b1);
        while (sb_q.size() != 0 && n < 10) begin
            if (rd.dout_valid) begin
                exp = sb_q.pop_front();
                checks++;
                if (rd.dout !== exp) begin failures++; $display("FAIL clr_seq_restart got=%h exp=%h", rd.dout, exp); end
            end
            @(negedge clk);
            n++;
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL clr_timeout left=%0d exp=0", sb_q.size()); end
        $display("test_clear done");
    endtask

    task automatic test_reset_mid();
        ts_entry_t exp;
        int n = 0;
        rd.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) fire(6'(1 << (i % N_CH)), 1'b1);
        checks++; if (level !== 10'd5) begin failures++; $display("FAIL rmid_prefill got=%0d exp=5", level); end
        rd.dout_ready = 1'b1;
        exp = sb_q.pop_front();
        checks++; if (rd.dout !== exp) begin failures++; $display("FAIL rmid_first got=%h exp=%h", rd.dout, exp); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (level !== '0 || rd.dout_valid !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL rmid_async level=%0d valid=%b full=%b exp 0/0/0", level, rd.dout_valid, full);
        end
        checks++; if (rd.dout !== 64'd0) begin failures++; $display("FAIL rmid_dout got=%h exp=0", rd.dout); end
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        exp_seq = 0;
        rd.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (level !== '0 || rd.dout_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_after level=%0d valid=%b exp 0/0", level, rd.dout_valid);
        end
        rd.dout_ready = 1'b1;
        fire(6'b100000, 1'b1);
        while (sb_q.size() != 0 && n < 10) begin
            if (rd.dout_valid) begin
                exp = sb_q.pop_front();
                checks++;
                if (rd.dout !== exp) begin failures++; $display("FAIL rmid_fresh got=%h exp=%h", rd.dout, exp); end
            end
            @(negedge clk);
            n++;
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL rmid_timeout left=%0d exp=0", sb_q.size()); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rd.dout_ready = 1'b0;
        test_reset();
        test_single();
        test_coincident();
        test_overflow();
        test_full_push_pop();
        test_ts_reset();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
